// File: rtl/apb_counter_slave.sv
`timescale 1ns/1ps
// APB3 completer wrapping a free-running up-counter. It exposes CTRL, LOAD_VAL, COUNT and a
// sticky WRAP status. The live count and a one-cycle wrap pulse also go to neighbouring logic.
module apb_counter_slave #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic [WIDTH-1:0]  count,
   output logic              c_out
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   localparam logic [1:0] AddrCtrl   = 2'd0;
   localparam logic [1:0] AddrLoad   = 2'd1;
   localparam logic [1:0] AddrCount  = 2'd2;
   localparam logic [1:0] AddrStatus = 2'd3;

   state_e             state_q, state_d;
   logic [1:0]         wait_q, wait_d;
   logic               pready_q, pready_d;
   logic               pslverr_q, pslverr_d;
   logic [31:0]        prdata_q, prdata_d;
   logic               en_q, en_d;
   logic [WIDTH-1:0]   load_val_q, load_val_d;
   logic [WIDTH-1:0]   count_q, count_d;
   logic               wrap_q, wrap_d;
   logic               c_out_q, c_out_d;

   logic [1:0]  reg_sel;
   logic        addr_ok;
   logic        bus_err;
   logic        commit;
   logic        wr_ok;
   logic        do_load;
   logic        wrap_evt;
   logic [31:0] rd_val;
   logic        unused_in;

   assign unused_in = ^{pwdata, paddr};

   assign reg_sel  = paddr[3:2];
   assign addr_ok  = (paddr[1:0] == 2'b00);
   assign bus_err  = !addr_ok || (pwrite && reg_sel == AddrCount);
   assign commit   = (state_q == StAccess) && psel && penable && pready_q;
   assign wr_ok    = commit && pwrite && addr_ok;
   assign do_load  = wr_ok && (reg_sel == AddrCtrl) && pwdata[1];
   // A load takes priority over the increment, so loading all-ones never counts as a wrap.
   assign wrap_evt = !do_load && en_q && (count_q == {WIDTH{1'b1}});

   // Register-file and counter next state.
   always_comb begin
      en_d       = en_q;
      load_val_d = load_val_q;
      count_d    = count_q;
      wrap_d     = wrap_q;
      c_out_d    = wrap_evt;
      if (wr_ok && reg_sel == AddrCtrl) en_d = pwdata[0];
      if (wr_ok && reg_sel == AddrLoad) load_val_d = pwdata[WIDTH-1:0];
      // Load uses LOAD_VAL as held before this edge.
      if (do_load) count_d = load_val_q;
      else if (en_q) count_d = count_q + WIDTH'(1);
      // Set wins over a simultaneous W1C.
      if (wrap_evt) wrap_d = 1'b1;
      else if (wr_ok && reg_sel == AddrStatus && pwdata[0]) wrap_d = 1'b0;
   end

   // Read mux on next-state values: the registered prdata then shows the state of the
   // completing cycle, i.e. COUNT before the completing edge's increment.
   always_comb begin
      rd_val = '0;
      case (reg_sel)
         AddrCtrl:   rd_val[0] = en_d;
         AddrLoad:   rd_val[WIDTH-1:0] = load_val_d;
         AddrCount:  rd_val[WIDTH-1:0] = count_d;
         default:    rd_val[0] = wrap_d;
      endcase
   end

   // Bus FSM next state and registered response.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      case (state_q)
         StIdle: begin
            if (psel && !penable) state_d = StSetup;
         end
         StSetup: begin
            if (!psel) begin
               state_d = StIdle;
            end else begin
               state_d  = StAccess;
               wait_d   = 2'd0;
               pready_d = (WAIT_STATES == 0);
            end
         end
         StAccess: begin
            if (!psel) begin
               state_d = StIdle;
            end else if (pready_q) begin
               state_d = (psel && !penable) ? StSetup : StIdle;
            end else begin
               wait_d   = wait_q + 2'd1;
               pready_d = ((32'(wait_q) + 32'd1) == WAIT_STATES);
            end
         end
         default: state_d = StIdle;
      endcase
      if (pready_d) begin
         pslverr_d = bus_err;
         prdata_d  = bus_err ? 32'd0 : rd_val;
      end
   end

   // State update with asynchronous reset.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         wait_q     <= 2'd0;
         pready_q   <= 1'b0;
         pslverr_q  <= 1'b0;
         prdata_q   <= '0;
         en_q       <= 1'b0;
         load_val_q <= '0;
         count_q    <= '0;
         wrap_q     <= 1'b0;
         c_out_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         pready_q   <= pready_d;
         pslverr_q  <= pslverr_d;
         prdata_q   <= prdata_d;
         en_q       <= en_d;
         load_val_q <= load_val_d;
         count_q    <= count_d;
         wrap_q     <= wrap_d;
         c_out_q    <= c_out_d;
      end
   end

   assign prdata  = prdata_q;
   assign pready  = pready_q;
   assign pslverr = pslverr_q;
   assign count   = count_q;
   assign c_out   = c_out_q;

endmodule
